// File: rtl/pe_pkg.sv
// pe_pkg: shared code/line widths and pulse FSM state type
package pe_pkg;
  localparam int CODE_W = 3;
  localparam int LINES = 8;
  typedef enum logic {IDLE, DRIVE} state_e;
endpackage

// File: rtl/dec_3x8_en.sv
// dec_3x8_en: combinational enabled 3-to-8 decoder; en_i low forces onehot_o to zero
module dec_3x8_en
  import pe_pkg::*;
(
  input  logic              en_i,
  input  logic [CODE_W-1:0] code_i,
  output logic [LINES-1:0]  onehot_o
);
  assign onehot_o = en_i ? {{(LINES-1){1'b0}}, 1'b1} << code_i : '0;
endmodule

// File: rtl/pulse_decoder_3x8.sv
// pulse_decoder_3x8: accepts a 3-bit code via valid/ready and holds its one-hot line for PULSE_LEN cycles (clk, rst_n sync active-low, en, in_code/in_valid/in_ready, out/out_valid)
module pulse_decoder_3x8
  import pe_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LINES-1:0]  out,
  output logic              out_valid
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0] out_q, out_d, dec;
  logic accept, hold;
  assign in_ready = rst_n & en & (state_q == IDLE | (state_q == DRIVE & cnt_q == '0));
  assign accept = in_valid & in_ready;
  assign hold = state_q == DRIVE && cnt_q != '0;
  dec_3x8_en u_dec (
    .en_i(accept),
    .code_i(in_code),
    .onehot_o(dec)
  );
  always_comb begin
    state_d = accept || hold ? DRIVE : IDLE;
    cnt_d = accept ? CNT_W'(PULSE_LEN - 1) : hold ? cnt_q - 1'b1 : '0;
    out_d = accept ? dec : hold ? out_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  assign out = out_q;
  assign out_valid = state_q == DRIVE;
endmodule

// File: tb/tb_pulse_decoder_3x8.sv
// tb_pulse_decoder_3x8: scoreboard bench over PULSE_LEN 4, 1 and 8 instances sharing one stimulus stream
module tb_pulse_decoder_3x8;
  logic clk = 1'b0;
  logic rst_n, en, in_valid;
  logic [2:0] in_code;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  task automatic chk(input int pl, input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL len%0d %s actual=%h expected=%h t=%0t", pl, n, a, e, $time);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int PL = g == 0 ? 4 : g == 1 ? 1 : 8;
    logic rdy, ov;
    logic [7:0] o, e;
    logic [7:0] q[$];
    pulse_decoder_3x8 #(.PULSE_LEN(PL), .CNT_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .in_code(in_code),
      .in_valid(in_valid),
      .in_ready(rdy),
      .out(o),
      .out_valid(ov)
    );
    always @(posedge clk) begin
      if (!rst_n) q.delete();
      else if (in_valid && en && q.size() == 0)
        for (int i = 0; i < PL; i++) q.push_back(8'd1 << in_code);
    end
    always @(negedge clk) begin
      e = q.size() != 0 ? q.pop_front() : 8'h00;
      chk(PL, "out", o, e);
      chk(PL, "out_valid", 8'(ov), 8'(e != 8'h00));
      chk(PL, "onehot0", 8'($onehot0(o)), 8'd1);
      chk(PL, "in_ready", 8'(rdy), 8'(rst_n && en && q.size() == 0));
    end
  end
  task automatic cyc(input bit r, input bit e, input bit v, input logic [2:0] c, input int n);
    rst_n = r;
    en = e;
    in_valid = v;
    in_code = c;
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask
  initial begin
    cyc(0, 1, 1, 3'd5, 2);
    cyc(1, 1, 0, 3'd0, 3);
    cyc(1, 1, 1, 3'd3, 1);
    cyc(1, 1, 0, 3'd0, 10);
    cyc(1, 1, 1, 3'd7, 1);
    cyc(1, 1, 1, 3'd0, 4);
    cyc(1, 1, 0, 3'd0, 12);
    cyc(1, 0, 1, 3'd2, 5);
    cyc(1, 1, 1, 3'd1, 1);
    cyc(1, 0, 1, 3'd4, 10);
    cyc(1, 1, 0, 3'd0, 2);
    for (int c = 0; c < 8; c++) cyc(1, 1, 1, 3'(c), 1);
    cyc(1, 1, 0, 3'd0, 12);
    cyc(1, 1, 1, 3'd6, 1);
    cyc(1, 1, 0, 3'd0, 2);
    cyc(0, 1, 1, 3'd6, 1);
    cyc(1, 1, 0, 3'd0, 3);
    repeat (600)
      cyc($urandom_range(15) != 0, $urandom_range(3) != 0, $urandom_range(1) == 1, 3'($urandom), 1);
    cyc(1, 1, 0, 3'd0, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
